a2_deserializer: RTL
====================

# a2_deserializer

Serial-to-parallel receiver for the team's serial link: collects MSB-first bits framed by a valid strobe and emits one parallel word plus its bit count per burst. Sits at the far end of the serializer link and hands assembled words to downstream logic as single-cycle pulses. Ends a word when the valid strobe drops or when WIDTH bits have been collected.

## Interface
- WIDTH, 8: maximum word width in bits.
- CNT_W, $clog2(WIDTH+1): derived localparam, width of the bit counter and data_mod_o.
- clk_i  input  1  clock; all logic on the rising edge.
- arst_i  input  1  asynchronous, active-high reset.
- ser_data_i  input  1  serial data bit; ignored when ser_data_val_i=0.
- ser_data_val_i  input  1  bit valid; a contiguous high run is one burst.
- data_o  output  WIDTH  assembled word; first received bit in data_o[WIDTH-1].
- data_mod_o  output  CNT_W  number of valid bits in data_o (1..WIDTH).
- data_val_o  output  1  one-cycle pulse qualifying data_o/data_mod_o.
- busy_o  output  1  high while a burst is partially collected.
- short_err_o  output  1  one-cycle pulse: burst shorter than MIN_BURST dropped.

## Operation
- States: IDLE (count=0), RECV (1 ≤ count < WIDTH).
- IDLE, val=1: store bit at position WIDTH-1, count←1, go RECV.
- RECV, val=1: store bit at position WIDTH-1-count, count←count+1.
- Word closes on:
  - val=0 in RECV, with count bits held; or
  - val=1 when the incoming bit is bit WIDTH. That bit is included, count=WIDTH.
- On close: data_o←collected bits, unfilled LSBs zero; data_mod_o←count; data_val_o←1 for one cycle; internal count←0, state←IDLE.
- After a WIDTH-fill close with val still high, the next valid bit starts a new word in IDLE. No gap cycle is required.
- val=0 in IDLE: no action.
- data_o/data_mod_o hold their last values between pulses.
- data_val_o and short_err_o never assert in the same cycle.
- busy_o = (state==RECV), registered.
- Reset mid-burst: partial word discarded, no pulse.

## Timing
- Reset values: data_o=0, data_mod_o=0, data_val_o=0, busy_o=0, short_err_o=0, count=0, state IDLE.
- Last bit sampled at edge N, val=0 at edge N+1: data_val_o high during cycle after N+1.
- WIDTH-fill: data_val_o high during cycle after edge N, the edge that samples bit WIDTH.
- busy_o rises after the first bit's edge and falls after the closing edge.
- Throughput: back-to-back WIDTH-bit words at one bit per clock, no loss.

## Configuration
- A2_DESER_LEN_CHECK_EN defined:
  - A burst closed by val=0 with count < MIN_BURST (3) is dropped: no data_val_o, data_o unchanged.
  - short_err_o pulses one cycle at the closing edge instead.
- A2_DESER_LEN_CHECK_EN undefined:
  - Every burst of ≥1 bit is emitted.
  - short_err_o is tied to 0.

## Structure
- Package a2_ser_pkg holds:
  - state enum (IDLE, RECV);
  - MIN_BURST=3;
  - a helper function computing CNT_W from WIDTH.
  - The same package is shared with the serializer.
- Single module, no sub-module.
- Word register and counter are written in one always_ff with async reset.

## Test plan
- 8-bit burst 1,0,1,1,0,0,1,0 at WIDTH=8, val high 8 cycles -> data_o=8'hB2, data_mod_o=8, data_val_o pulses the cycle after bit 8.
- 5-bit burst 1,1,0,0,1 then val low -> data_o=8'b11001000, data_mod_o=5, pulse one cycle after val drops, busy_o high 5 cycles.
- 16 contiguous valid bits (0xA5 then 0x3C) -> two pulses 8 cycles apart, data_o=8'hA5 then 8'h3C, data_mod_o=8 both, no idle pulse after.
- 2-bit burst with A2_DESER_LEN_CHECK_EN -> short_err_o pulse, no data_val_o, data_o unchanged; without macro -> data_o=8'b(b1 b0 000000), data_mod_o=2.
- arst_i asserted after 4 bits of a burst -> all outputs 0 immediately, no pulse; next 3-bit burst 1,0,1 -> data_o=8'hA0, data_mod_o=3.
- Toggling ser_data_i with val=0 for 10 cycles in IDLE -> no pulses, busy_o=0, outputs unchanged.

Source files
------------

// File: rtl/a2_ser_pkg.sv
// Shared definitions for the a2 serial link (serializer and deserializer).
package a2_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Bursts shorter than this are dropped when the length check is enabled.
  localparam int MIN_BURST = 3;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/a2_deserializer_if.sv
// Serial input stream and parallel word output bundle of the a2 deserializer.
interface a2_deserializer_if #(
  parameter int WIDTH = 8
);
  import a2_ser_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);

  logic             ser_data_i;
  logic             ser_data_val_i;
  logic [WIDTH-1:0] data_o;
  logic [CNT_W-1:0] data_mod_o;
  logic             data_val_o;
  logic             busy_o;
  logic             short_err_o;

  modport master (
    output ser_data_i, ser_data_val_i,
    input  data_o, data_mod_o, data_val_o, busy_o, short_err_o
  );

  modport slave (
    input  ser_data_i, ser_data_val_i,
    output data_o, data_mod_o, data_val_o, busy_o, short_err_o
  );

endinterface

// File: rtl/a2_deserializer.sv
// MSB-first serial-to-parallel receiver; one word per valid burst or per WIDTH bits.
// Optional short-burst rejection is enabled by defining A2_DESER_LEN_CHECK_EN.
module a2_deserializer
  import a2_ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             arst_i,
  a2_deserializer_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] mod_q;
  logic             val_q;
  logic             last_bit;
`ifdef A2_DESER_LEN_CHECK_EN
  logic             short_q;
`endif

  assign last_bit = (count == LAST_CNT);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.ser_data_val_i && !last_bit) state_next = RECV;
      RECV: if (!bus.ser_data_val_i || last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o     = (state == RECV);
    bus.data_o     = data_q;
    bus.data_mod_o = mod_q;
    bus.data_val_o = val_q;
`ifdef A2_DESER_LEN_CHECK_EN
    bus.short_err_o = short_q;
`else
    bus.short_err_o = 1'b0;
`endif
  end

  // A new burst starts from a clean word so unfilled LSBs read as zero.
  always_comb begin
    acc_next = (state == IDLE) ? '0 : acc;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1 - int'(count)) acc_next[i] = bus.ser_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      acc    <= '0;
      count  <= '0;
      data_q <= '0;
      mod_q  <= '0;
      val_q  <= 1'b0;
`ifdef A2_DESER_LEN_CHECK_EN
      short_q <= 1'b0;
`endif
    end else begin
      val_q <= 1'b0;
`ifdef A2_DESER_LEN_CHECK_EN
      short_q <= 1'b0;
`endif
      if (bus.ser_data_val_i) begin
        if (last_bit) begin
          data_q <= acc_next;
          mod_q  <= FULL_CNT;
          val_q  <= 1'b1;
          acc    <= '0;
          count  <= '0;
        end else begin
          acc   <= acc_next;
          count <= count + CNT_W'(1);
        end
      end else if (count != '0) begin
`ifdef A2_DESER_LEN_CHECK_EN
        if (int'(count) < MIN_BURST) begin
          short_q <= 1'b1;
        end else begin
          data_q <= acc;
          mod_q  <= count;
          val_q  <= 1'b1;
        end
`else
        data_q <= acc;
        mod_q  <= count;
        val_q  <= 1'b1;
`endif
        acc   <= '0;
        count <= '0;
      end
    end
  end

endmodule
